axis_pixel_streamer: RTL

- AXI-Stream master (transmitter) that feeds pixel words into the image-processing IPs, e.g. the slave port of the image inverter.
- Software-side writes buffer pixel words in an internal FIFO; the block emits them as fixed-length frames using the valid/ready handshake.
- Sits between the processor write path and the inverter's s_axis input.

---
 rtl/axis_pixel_streamer_pkg.sv | 26 ++
 rtl/axis_pixel_streamer_if.sv | 38 +++
 rtl/axis_pixel_streamer_fifo.sv | 64 ++++++
 rtl/axis_pixel_streamer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/axis_pixel_streamer_pkg.sv
// ---------------------------------------------------------------------------
// pix_stream_pkg
// Shared definitions for the AXI-Stream pixel streamer:
//   - default parameter values (data width, FIFO depth, frame-length width)
//   - FSM state encoding
//   - pointer-width helper for the wrap-bit FIFO
// Optional feature macro used elsewhere in this slice: PIX_STREAM_TLAST_EN.
// ---------------------------------------------------------------------------
package pix_stream_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_LEN_W      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } pix_state_e;

    // Address bits plus one wrap bit, so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_pixel_streamer_if.sv
// ---------------------------------------------------------------------------
// axis_pixel_streamer_if
// AXI-Stream bus between the pixel streamer (master) and a downstream IP
// (slave).
//   valid : beat valid            (master -> slave)
//   data  : pixel word            (master -> slave)
//   last  : last beat of a frame  (master -> slave, only with
//           PIX_STREAM_TLAST_EN defined)
//   ready : downstream ready      (slave -> master)
// ---------------------------------------------------------------------------
interface axis_pixel_streamer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;
`ifdef PIX_STREAM_TLAST_EN
    logic                  last;
`endif

    modport master (
        output valid,
        output data,
`ifdef PIX_STREAM_TLAST_EN
        output last,
`endif
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
`ifdef PIX_STREAM_TLAST_EN
        input  last,
`endif
        output ready
    );
endinterface

// File: rtl/axis_pixel_streamer_fifo.sv
// ---------------------------------------------------------------------------
// pix_stream_fifo
// Synchronous FIFO with wrap-bit pointers that buffers pixel words between
// the write path and the streaming output register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, push_data : write request and word; ignored while full
//   pop          : consume the head entry (ignored while empty)
//   head_data    : current head entry (valid when !empty)
//   full, empty  : occupancy flags
//   overflow     : sticky, set by a push attempted while full
//   level        : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module pix_stream_fifo
    import pix_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    head_data,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [ptr_w(DEPTH)-1:0]  level
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wptr, rptr;
    logic                  do_push, do_pop;

    assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty     = (wptr == rptr);
    assign level     = wptr - rptr;
    assign head_data = mem[rptr[AW-1:0]];

    // Full is judged on the registered pointers: a same-cycle pop does not
    // open a slot for the incoming word.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)     wptr     <= wptr + PTR_W'(1);
            if (do_pop)      rptr     <= rptr + PTR_W'(1);
            if (push & full) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_pixel_streamer.sv
// ---------------------------------------------------------------------------
// axis_pixel_streamer
// AXI-Stream master that emits buffered pixel words as fixed-length frames.
// Words written via wr_en/wr_data are queued in pix_stream_fifo; a frame FSM
// (IDLE -> STREAM -> DONE) moves frame_len beats through a single output
// register onto m_axis.
// Ports:
//   axi_clk, axi_reset_n : clock, asynchronous active-low reset
//   wr_en, wr_data       : enqueue one pixel word
//   wr_full, wr_overflow : FIFO full, sticky dropped-write flag
//   en, frame_len        : start a frame (checked in IDLE only)
//   m_axis               : AXI-Stream master port (valid/data/ready[/last])
//   frame_done           : one-cycle pulse after a frame's last beat is taken
//   fifo_level           : FIFO occupancy
// Build option: define PIX_STREAM_TLAST_EN to add m_axis.last.
// ---------------------------------------------------------------------------
module axis_pixel_streamer
    import pix_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                         axi_clk,
    input  logic                         axi_reset_n,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_full,
    output logic                         wr_overflow,
    input  logic                         en,
    input  logic [LEN_W-1:0]             frame_len,
    axis_pixel_streamer_if.master        m_axis,
    output logic                         frame_done,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    pix_state_e            state;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      beat_cnt;   // beats accepted downstream
    logic [LEN_W-1:0]      load_cnt;   // beats loaded into the output register
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  fifo_empty;
    logic                  hs, load;

    pix_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (axi_clk),
        .rst_n     (axi_reset_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (load),
        .head_data (head_data),
        .full      (wr_full),
        .empty     (fifo_empty),
        .overflow  (wr_overflow),
        .level     (fifo_level)
    );

    assign hs = valid_q & m_axis.ready;

    // Refill the output register when it is free or being drained this cycle,
    // but never past the frame length so the next frame's words stay queued.
    assign load = (~valid_q | hs) & ~fifo_empty & (state == STREAM) & (load_cnt < len_q);

    assign m_axis.valid = valid_q;
    assign m_axis.data  = data_q;

`ifdef PIX_STREAM_TLAST_EN
    logic last_q;
    assign m_axis.last = last_q;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n)  last_q <= 1'b0;
        else if (load)     last_q <= (load_cnt == len_q - LEN_W'(1));
    end
`endif

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state      <= IDLE;
            len_q      <= '0;
            beat_cnt   <= '0;
            load_cnt   <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (load) begin
                data_q   <= head_data;
                valid_q  <= 1'b1;
                load_cnt <= load_cnt + LEN_W'(1);
            end else if (hs) begin
                valid_q  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en && (frame_len != '0)) begin
                        len_q    <= frame_len;
                        beat_cnt <= '0;
                        load_cnt <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (beat_cnt == len_q - LEN_W'(1)) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
